// File: rtl/team_08_wb_pkg.sv
// Shared types and bus widths for the team_08 Wishbone initiator.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package team_08_wb_pkg;
    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wbm_state_t;
endpackage

// File: rtl/team_08_wb_master_if.sv
// Command/response port plus Wishbone classic bus of the initiator.
// Latency: n/a (wiring only).
// Backpressure: cmd valid/ready in, held rsp valid/ready out.
interface team_08_wb_master_if;
    import team_08_wb_pkg::*;

    logic                cmd_valid_i;
    logic                cmd_ready_o;
    logic                cmd_we_i;
    logic [WB_ADR_W-1:0] cmd_adr_i;
    logic [WB_DAT_W-1:0] cmd_dat_i;
    logic [WB_SEL_W-1:0] cmd_sel_i;
    logic                rsp_valid_o;
    logic                rsp_ready_i;
    logic [WB_DAT_W-1:0] rsp_dat_o;
    logic                rsp_err_o;
    logic                cyc_o;
    logic                stb_o;
    logic                we_o;
    logic [WB_ADR_W-1:0] adr_o;
    logic [WB_DAT_W-1:0] dat_o;
    logic [WB_SEL_W-1:0] sel_o;
    logic [WB_DAT_W-1:0] dat_i;
    logic                ack_i;

    // Initiator side: the DUT.
    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  rsp_ready_i, dat_i, ack_i,
        output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o
    );

    // Environment side: command source, response sink and bus slave.
    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output rsp_ready_i, dat_i, ack_i,
        input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o
    );
endinterface

// File: rtl/team_08_wb_timeout.sv
// Saturating wait-cycle counter; expired flags the last allowed strobe cycle.
// Latency: expired is combinational from the registered count.
// Backpressure: none; en advances, clr restarts, count holds at its limit.
module team_08_wb_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Count strobe cycles without ack; stop at the limit so it never wraps.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == LAST);
endmodule

// File: rtl/team_08_wb_master.sv
// Single-transfer Wishbone classic initiator with timeout.
// Latency: accept->stb 1 cycle, ack->rsp_valid 1 cycle, 3 cycles min per transfer.
// Backpressure: cmd_ready only in IDLE; response held until rsp_ready.
module team_08_wb_master
    import team_08_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    team_08_wb_master_if.master bus
);
    wbm_state_t          state;
    wbm_state_t          state_nxt;
    logic                lat_we;
    logic [WB_ADR_W-1:0] lat_adr;
    logic [WB_DAT_W-1:0] lat_dat;
    logic [WB_SEL_W-1:0] lat_sel;
    logic [WB_DAT_W-1:0] rsp_dat;
    logic                rsp_err;
    logic                expired;

    // Counter restarts on every IDLE cycle so each transfer gets a full budget.
    team_08_wb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk_i),
        .rst     (rst_i),
        .clr     (state == IDLE),
        .en      (state == BUS),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake/strobe outputs; ack takes priority over timeout.
    always_comb begin
        state_nxt       = state;
        bus.cmd_ready_o = 1'b0;
        bus.cyc_o       = 1'b0;
        bus.stb_o       = 1'b0;
        bus.rsp_valid_o = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready_o = 1'b1;
                if (bus.cmd_valid_i) begin
                    state_nxt = BUS;
                end
            end
            BUS: begin
                bus.cyc_o = 1'b1;
                bus.stb_o = 1'b1;
                if (bus.ack_i || expired) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid_o = 1'b1;
                if (bus.rsp_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the command on accept and capture the outcome when BUS ends.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lat_we  <= 1'b0;
            lat_adr <= '0;
            lat_dat <= '0;
            lat_sel <= '0;
            rsp_dat <= '0;
            rsp_err <= 1'b0;
        end else begin
            if ((state == IDLE) && bus.cmd_valid_i) begin
                lat_we  <= bus.cmd_we_i;
                lat_adr <= bus.cmd_adr_i;
                lat_dat <= bus.cmd_dat_i;
                lat_sel <= bus.cmd_sel_i;
            end
            if (state == BUS) begin
                if (bus.ack_i) begin
                    rsp_dat <= lat_we ? '0 : bus.dat_i;
                    rsp_err <= 1'b0;
                end else if (expired) begin
                    rsp_dat <= '0;
                    rsp_err <= 1'b1;
                end
            end
        end
    end

    // Bus fields come straight from the latch so they stay stable across waits.
    assign bus.we_o      = lat_we;
    assign bus.adr_o     = lat_adr;
    assign bus.dat_o     = lat_dat;
    assign bus.sel_o     = lat_sel;
    assign bus.rsp_dat_o = rsp_dat;
    assign bus.rsp_err_o = rsp_err;
endmodule

// File: tb/tb_team_08_wb_master.sv
// Directed bench for team_08_wb_master: two instances (timeout 8 and 4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Each task checks its own scenario inline and steps the shared counters.
module tb_team_08_wb_master;
    import team_08_wb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    team_08_wb_master_if bus_a ();
    team_08_wb_master_if bus_b ();

    team_08_wb_master #(.TIMEOUT_CYCLES(8)) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a.master)
    );

    team_08_wb_master #(.TIMEOUT_CYCLES(4)) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b.master)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        bus_a.cmd_valid_i = 1'b0; bus_a.cmd_we_i = 1'b0; bus_a.cmd_adr_i = '0;
        bus_a.cmd_dat_i = '0; bus_a.cmd_sel_i = '0; bus_a.rsp_ready_i = 1'b0;
        bus_a.dat_i = '0; bus_a.ack_i = 1'b0;
        bus_b.cmd_valid_i = 1'b0; bus_b.cmd_we_i = 1'b0; bus_b.cmd_adr_i = '0;
        bus_b.cmd_dat_i = '0; bus_b.cmd_sel_i = '0; bus_b.rsp_ready_i = 1'b0;
        bus_b.dat_i = '0; bus_b.ack_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({bus_a.cmd_ready_o, bus_a.cyc_o, bus_a.stb_o, bus_a.we_o, bus_a.rsp_valid_o, bus_a.rsp_err_o} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_ctrl_a got=%b exp=100000",
                     {bus_a.cmd_ready_o, bus_a.cyc_o, bus_a.stb_o, bus_a.we_o, bus_a.rsp_valid_o, bus_a.rsp_err_o});
        end
        checks++;
        if ({bus_a.adr_o, bus_a.dat_o, bus_a.sel_o, bus_a.rsp_dat_o} !== 100'd0) begin
            failures++;
            $display("FAIL reset_data_a adr=%h dat=%h sel=%h rsp_dat=%h exp=all zero",
                     bus_a.adr_o, bus_a.dat_o, bus_a.sel_o, bus_a.rsp_dat_o);
        end
        checks++;
        if ({bus_b.cmd_ready_o, bus_b.cyc_o, bus_b.stb_o, bus_b.rsp_valid_o} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_ctrl_b got=%b exp=1000",
                     {bus_b.cmd_ready_o, bus_b.cyc_o, bus_b.stb_o, bus_b.rsp_valid_o});
        end
    endtask

    task automatic test_write_zero_wait();
        bus_a.cmd_valid_i = 1'b1; bus_a.cmd_we_i = 1'b1;
        bus_a.cmd_adr_i = 32'h3000_0004; bus_a.cmd_dat_i = 32'hDEAD_BEEF; bus_a.cmd_sel_i = 4'hF;
        tick();
        bus_a.cmd_valid_i = 1'b0; bus_a.cmd_dat_i = 32'h0;
        checks++;
        if ({bus_a.cyc_o, bus_a.stb_o, bus_a.we_o, bus_a.cmd_ready_o} !== 4'b1110 ||
            bus_a.adr_o !== 32'h3000_0004 || bus_a.dat_o !== 32'hDEAD_BEEF || bus_a.sel_o !== 4'hF) begin
            failures++;
            $display("FAIL wr_bus cyc/stb/we/rdy=%b adr=%h dat=%h sel=%h exp=1110 30000004 deadbeef f",
                     {bus_a.cyc_o, bus_a.stb_o, bus_a.we_o, bus_a.cmd_ready_o}, bus_a.adr_o, bus_a.dat_o, bus_a.sel_o);
        end
        bus_a.ack_i = 1'b1; bus_a.dat_i = 32'hFFFF_FFFF;
        tick();
        bus_a.ack_i = 1'b0; bus_a.dat_i = 32'h0;
        checks++;
        if ({bus_a.rsp_valid_o, bus_a.rsp_err_o, bus_a.cyc_o, bus_a.stb_o, bus_a.cmd_ready_o} !== 5'b10000 ||
            bus_a.rsp_dat_o !== 32'h0) begin
            failures++;
            $display("FAIL wr_rsp vld/err/cyc/stb/rdy=%b rsp_dat=%h exp=10000 00000000",
                     {bus_a.rsp_valid_o, bus_a.rsp_err_o, bus_a.cyc_o, bus_a.stb_o, bus_a.cmd_ready_o}, bus_a.rsp_dat_o);
        end
        bus_a.rsp_ready_i = 1'b1;
        tick();
        bus_a.rsp_ready_i = 1'b0;
        checks++;
        if ({bus_a.cmd_ready_o, bus_a.rsp_valid_o} !== 2'b10) begin
            failures++;
            $display("FAIL wr_back_idle rdy/vld=%b exp=10", {bus_a.cmd_ready_o, bus_a.rsp_valid_o});
        end
    endtask

    task automatic test_read_wait3();
        bus_a.cmd_valid_i = 1'b1; bus_a.cmd_we_i = 1'b0;
        bus_a.cmd_adr_i = 32'h3000_0008; bus_a.cmd_sel_i = 4'hF;
        tick();
        bus_a.cmd_valid_i = 1'b0; bus_a.cmd_adr_i = 32'h0;
        bus_a.dat_i = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus_a.stb_o !== 1'b1 || bus_a.we_o !== 1'b0 || bus_a.adr_o !== 32'h3000_0008) begin
                failures++;
                $display("FAIL rd_wait_cycle%0d stb=%b we=%b adr=%h exp=1 0 30000008",
                         i, bus_a.stb_o, bus_a.we_o, bus_a.adr_o);
            end
            if (i == 3) begin
                bus_a.ack_i = 1'b1; bus_a.dat_i = 32'h1234_5678;
            end
            tick();
        end
        bus_a.ack_i = 1'b0; bus_a.dat_i = 32'h0;
        checks++;
        if ({bus_a.rsp_valid_o, bus_a.rsp_err_o, bus_a.stb_o} !== 3'b100 || bus_a.rsp_dat_o !== 32'h1234_5678) begin
            failures++;
            $display("FAIL rd_rsp vld/err/stb=%b rsp_dat=%h exp=100 12345678",
                     {bus_a.rsp_valid_o, bus_a.rsp_err_o, bus_a.stb_o}, bus_a.rsp_dat_o);
        end
        bus_a.rsp_ready_i = 1'b1;
        tick();
        bus_a.rsp_ready_i = 1'b0;
    endtask

    task automatic test_timeout();
        int stb_cnt = 0;
        bus_a.cmd_valid_i = 1'b1; bus_a.cmd_we_i = 1'b0; bus_a.cmd_adr_i = 32'h3000_0010;
        tick();
        bus_a.cmd_valid_i = 1'b0;
        bus_a.dat_i = 32'hCAFE_CAFE;
        for (int i = 0; i < 20 && bus_a.stb_o === 1'b1; i++) begin
            stb_cnt++;
            tick();
        end
        bus_a.dat_i = 32'h0;
        checks++;
        if (stb_cnt != 8) begin
            failures++;
            $display("FAIL to_stb_cycles got=%0d exp=8", stb_cnt);
        end
        checks++;
        if ({bus_a.rsp_valid_o, bus_a.rsp_err_o} !== 2'b11 || bus_a.rsp_dat_o !== 32'h0) begin
            failures++;
            $display("FAIL to_rsp vld/err=%b rsp_dat=%h exp=11 00000000",
                     {bus_a.rsp_valid_o, bus_a.rsp_err_o}, bus_a.rsp_dat_o);
        end
        bus_a.ack_i = 1'b1; bus_a.dat_i = 32'hAAAA_5555;
        tick();
        bus_a.ack_i = 1'b0; bus_a.dat_i = 32'h0;
        checks++;
        if ({bus_a.rsp_valid_o, bus_a.rsp_err_o, bus_a.cyc_o} !== 3'b110 || bus_a.rsp_dat_o !== 32'h0) begin
            failures++;
            $display("FAIL to_late_ack vld/err/cyc=%b rsp_dat=%h exp=110 00000000",
                     {bus_a.rsp_valid_o, bus_a.rsp_err_o, bus_a.cyc_o}, bus_a.rsp_dat_o);
        end
        bus_a.rsp_ready_i = 1'b1;
        tick();
        bus_a.rsp_ready_i = 1'b0;
        bus_a.ack_i = 1'b1;
        tick();
        bus_a.ack_i = 1'b0;
        checks++;
        if ({bus_a.cmd_ready_o, bus_a.rsp_valid_o, bus_a.cyc_o} !== 3'b100) begin
            failures++;
            $display("FAIL idle_ack_ignored rdy/vld/cyc=%b exp=100",
                     {bus_a.cmd_ready_o, bus_a.rsp_valid_o, bus_a.cyc_o});
        end
    endtask

    task automatic test_backpressure();
        bus_a.cmd_valid_i = 1'b1; bus_a.cmd_we_i = 1'b0; bus_a.cmd_adr_i = 32'h3000_0020;
        tick();
        bus_a.ack_i = 1'b1; bus_a.dat_i = 32'h55AA_33CC;
        bus_a.cmd_we_i = 1'b1; bus_a.cmd_adr_i = 32'h3000_0030;
        bus_a.cmd_dat_i = 32'h0BAD_F00D; bus_a.cmd_sel_i = 4'h3;
        tick();
        bus_a.ack_i = 1'b0; bus_a.dat_i = 32'h0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus_a.rsp_valid_o, bus_a.cmd_ready_o, bus_a.cyc_o} !== 3'b100 ||
                bus_a.rsp_dat_o !== 32'h55AA_33CC || bus_a.rsp_err_o !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d vld/rdy/cyc=%b rsp_dat=%h err=%b exp=100 55aa33cc 0",
                         i, {bus_a.rsp_valid_o, bus_a.cmd_ready_o, bus_a.cyc_o}, bus_a.rsp_dat_o, bus_a.rsp_err_o);
            end
            tick();
        end
        bus_a.rsp_ready_i = 1'b1;
        tick();
        bus_a.rsp_ready_i = 1'b0;
        checks++;
        if ({bus_a.cmd_ready_o, bus_a.rsp_valid_o, bus_a.stb_o} !== 3'b100) begin
            failures++;
            $display("FAIL bp_release rdy/vld/stb=%b exp=100",
                     {bus_a.cmd_ready_o, bus_a.rsp_valid_o, bus_a.stb_o});
        end
        tick();
        bus_a.cmd_valid_i = 1'b0;
        checks++;
        if (bus_a.stb_o !== 1'b1 || bus_a.we_o !== 1'b1 || bus_a.adr_o !== 32'h3000_0030 ||
            bus_a.dat_o !== 32'h0BAD_F00D || bus_a.sel_o !== 4'h3) begin
            failures++;
            $display("FAIL bp_next_cmd stb=%b we=%b adr=%h dat=%h sel=%h exp=1 1 30000030 0badf00d 3",
                     bus_a.stb_o, bus_a.we_o, bus_a.adr_o, bus_a.dat_o, bus_a.sel_o);
        end
        bus_a.ack_i = 1'b1;
        tick();
        bus_a.ack_i = 1'b0;
        bus_a.rsp_ready_i = 1'b1;
        tick();
        bus_a.rsp_ready_i = 1'b0;
    endtask

    task automatic test_collision();
        bus_b.cmd_valid_i = 1'b1; bus_b.cmd_we_i = 1'b0;
        bus_b.cmd_adr_i = 32'h3000_0040; bus_b.cmd_sel_i = 4'hF;
        tick();
        bus_b.cmd_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus_b.stb_o !== 1'b1) begin
                failures++;
                $display("FAIL col_stb%0d got=%b exp=1", i, bus_b.stb_o);
            end
            if (i == 3) begin
                bus_b.ack_i = 1'b1; bus_b.dat_i = 32'h600D_F00D;
            end
            tick();
        end
        bus_b.ack_i = 1'b0; bus_b.dat_i = 32'h0;
        checks++;
        if ({bus_b.rsp_valid_o, bus_b.rsp_err_o} !== 2'b10 || bus_b.rsp_dat_o !== 32'h600D_F00D) begin
            failures++;
            $display("FAIL col_rsp vld/err=%b rsp_dat=%h exp=10 600df00d",
                     {bus_b.rsp_valid_o, bus_b.rsp_err_o}, bus_b.rsp_dat_o);
        end
        bus_b.rsp_ready_i = 1'b1;
        tick();
        bus_b.rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid_bus();
        int seen_vld = 0;
        bus_a.cmd_valid_i = 1'b1; bus_a.cmd_we_i = 1'b1;
        bus_a.cmd_adr_i = 32'h3000_0050; bus_a.cmd_dat_i = 32'h1111_2222; bus_a.cmd_sel_i = 4'hC;
        tick();
        bus_a.cmd_valid_i = 1'b0;
        tick();
        checks++;
        if (bus_a.stb_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre stb=%b exp=1", bus_a.stb_o);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({bus_a.cmd_ready_o, bus_a.cyc_o, bus_a.stb_o, bus_a.we_o, bus_a.rsp_valid_o, bus_a.rsp_err_o} !== 6'b100000 ||
            {bus_a.adr_o, bus_a.dat_o, bus_a.sel_o, bus_a.rsp_dat_o} !== 100'd0) begin
            failures++;
            $display("FAIL rst_mid_outputs ctrl=%b adr=%h dat=%h sel=%h rsp_dat=%h exp=100000 and zeros",
                     {bus_a.cmd_ready_o, bus_a.cyc_o, bus_a.stb_o, bus_a.we_o, bus_a.rsp_valid_o, bus_a.rsp_err_o},
                     bus_a.adr_o, bus_a.dat_o, bus_a.sel_o, bus_a.rsp_dat_o);
        end
        rst = 1'b0;
        bus_a.ack_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (bus_a.rsp_valid_o === 1'b1 || bus_a.stb_o === 1'b1) seen_vld++;
            tick();
        end
        bus_a.ack_i = 1'b0;
        checks++;
        if (seen_vld != 0) begin
            failures++;
            $display("FAIL rst_mid_no_rsp cycles_with_vld_or_stb=%0d exp=0", seen_vld);
        end
    endtask

    initial begin
        init_inputs();
        test_reset();
        test_write_zero_wait();
        test_read_wait3();
        test_timeout();
        test_backpressure();
        test_collision();
        test_reset_mid_bus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/team_08_wb_master.md
# team_08_wb_master

Single-transfer Wishbone classic initiator: the master-side counterpart to the team's Wishbone slave bus wrapper. It accepts one command at a time from a local valid/ready port and runs one read or write cycle on the Wishbone bus. It returns read data, or a timeout error, on a held response port. It lets on-chip logic and benches drive any `team_08` slave wrapper without hand-sequencing `cyc`, `stb` and `ack`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: cycles `stb_o` may stay high without `ack_i` before abort; legal range 1..65535.

Ports:
- `clk_i`  in  1  Clock; one clock domain only.
- `rst_i`  in  1  Reset; synchronous, active-high.
- `cmd_valid_i`  in  1  Command present.
- `cmd_ready_o`  out  1  Block can accept a command.
- `cmd_we_i`  in  1  1 = write, 0 = read.
- `cmd_adr_i`  in  32  Byte address.
- `cmd_dat_i`  in  32  Write data.
- `cmd_sel_i`  in  4  Byte lane select.
- `rsp_valid_o`  out  1  Response present; held until accepted.
- `rsp_ready_i`  in  1  Consumer accepts the response.
- `rsp_dat_o`  out  32  Read data; 0 for writes and errors.
- `rsp_err_o`  out  1  Transfer timed out.
- `cyc_o`, `stb_o`, `we_o`  out  1 each  Wishbone control signals.
- `adr_o`  out  32  Wishbone address.
- `dat_o`  out  32  Wishbone write data.
- `sel_o`  out  4  Wishbone byte lanes.
- `dat_i`  in  32  Wishbone read data.
- `ack_i`  in  1  Wishbone acknowledge.

## Operation
- FSM states: IDLE, BUS, RESP.
- **IDLE**
  - `cmd_ready_o` = 1.
  - When `cmd_valid_i` is high, latch we/adr/dat/sel, clear the timeout counter and go to BUS.
- **BUS**
  - `cyc_o` = `stb_o` = 1 and `cmd_ready_o` = 0.
  - `we_o`/`adr_o`/`dat_o`/`sel_o` are driven from the latched values and held stable for the whole cycle.
  - `ack_i` = 1: capture `dat_i` if reading (store 0 if writing), set err = 0, go to RESP.
  - No ack and counter == `TIMEOUT_CYCLES`-1: set data = 0, err = 1, go to RESP.
  - Otherwise: increment the counter.
  - If ack and timeout occur in the same cycle, ack wins.
- **RESP**
  - `rsp_valid_o` = 1, `cyc_o` = `stb_o` = 0, `cmd_ready_o` = 0.
  - When `rsp_ready_i` is high, go to IDLE.
  - `rsp_dat_o`/`rsp_err_o` stay stable while `rsp_valid_o` is high.
- `ack_i` is ignored outside BUS; a late ack arriving after a timeout has no effect.
- Only one transfer is ever outstanding; there is no pipelining and no burst.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)` and the counter never wraps.

## Timing
- Reset: state IDLE. All Wishbone outputs are 0, `rsp_valid_o` = 0, `rsp_dat_o` = 0, `rsp_err_o` = 0. `cmd_ready_o` = 1 in the first cycle after reset.
- `rst_i` asserted mid-transfer: `cyc_o`/`stb_o` are low on the next edge and the pending response is discarded.
- Command accepted at edge N: `cyc_o`/`stb_o` are high from cycle N+1.
- `ack_i` sampled high at edge M: `cyc_o`/`stb_o` are low and `rsp_valid_o` is high from cycle M+1.
- Zero-wait slave (ack in the first BUS cycle): command accept to `rsp_valid_o` takes 2 cycles.
- Timeout: `stb_o` is high for exactly `TIMEOUT_CYCLES` cycles, then `rsp_valid_o` rises the next cycle with `rsp_err_o` = 1.
- `rsp_ready_i` high in the first RESP cycle: `cmd_ready_o` is high in the following cycle, so at most one transfer completes every 3 cycles.
- `cmd_*` inputs are don't-care outside IDLE.

## Structure
- Shared package `team_08_wb_pkg` holds:
  - the state enum `wbm_state_t` (IDLE, BUS, RESP);
  - constants `WB_ADR_W` = 32, `WB_DAT_W` = 32, `WB_SEL_W` = 4.
- One sub-module, `team_08_wb_timeout`: a parameterized saturating counter with `clr` and `en` inputs and an `expired` output.
- The FSM and the data/response registers live in `team_08_wb_master`.

## Test plan
- **Write, zero-wait slave:** cmd we=1, adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF → one `stb_o` cycle with those values; after the ack, `rsp_valid_o`=1, `rsp_err_o`=0, `rsp_dat_o`=0.
- **Read, 3 wait states:** cmd we=0, adr=0x3000_0008; slave acks on the 4th `stb_o` cycle with `dat_i`=0x1234_5678 → `rsp_dat_o`=0x1234_5678, and `adr_o` stays stable all 4 cycles.
- **Timeout:** `TIMEOUT_CYCLES`=8, slave never acks → `stb_o` is high for exactly 8 cycles, then `rsp_err_o`=1 and `rsp_dat_o`=0; an ack injected afterwards is ignored.
- **Response backpressure:** `rsp_ready_i` held low for 5 cycles → `rsp_valid_o` and the data stay stable, `cmd_ready_o`=0, and a new `cmd_valid_i` is not accepted until the response is taken.
- **Ack/timeout collision:** `TIMEOUT_CYCLES`=4, ack arrives on the 4th `stb_o` cycle → `rsp_err_o`=0 and `rsp_dat_o` = sampled `dat_i`.
- **Reset mid-BUS:** `rst_i` pulsed during the 2nd wait cycle → all outputs match their reset values on the next edge; no `rsp_valid_o` appears.
